// File: rtl/pond_arb_pkg.sv
// pond_arb_pkg: shared widths, buffer depth and pending-write entry type for the pond port arbiter
package pond_arb_pkg;
  localparam int POND_ADDR_W = 5;
  localparam int POND_DATA_W = 16;
  localparam int POND_WBUF_DEPTH = 2;
  typedef struct packed {
    logic                   valid;
    logic [POND_ADDR_W-1:0] addr;
    logic [POND_DATA_W-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/pond_wbuf.sv
// pond_wbuf: in-order pending-write FIFO (entry 0 is oldest) with per-entry address match
module pond_wbuf
  import pond_arb_pkg::*;
#(
  parameter int DEPTH = POND_WBUF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  wbuf_entry_t            push_ent_i,
  input  logic [POND_ADDR_W-1:0] match_addr_i,
  output wbuf_entry_t            head_o,
  output logic [CW-1:0]          count_o,
  output logic [DEPTH-1:0]       match_o,
  output logic [POND_DATA_W-1:0] hit_data_o
);
  wbuf_entry_t   ent_q [DEPTH];
  wbuf_entry_t   ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d, widx;
  assign head_o  = ent_q[0];
  assign count_o = count_q;
  // pop shifts everything toward the head; a push lands right behind the last surviving entry
  always_comb begin
    widx    = pop_i ? count_q - CW'(1) : count_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (pop_i) ent_d[i] = (i == DEPTH - 1) ? wbuf_entry_t'('0) : ent_q[(i + 1) % DEPTH];
      if (push_i && widx == CW'(i)) ent_d[i] = push_ent_i;
    end
  end
  // address compare per entry; later (younger) matches override older ones for the hit data
  always_comb begin
    match_o    = '0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = ent_q[i].valid && ent_q[i].addr == match_addr_i;
      if (match_o[i]) hit_data_o = ent_q[i].data;
    end
  end
  // buffer state: cleared by reset or flush, frozen when the pipeline is stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_q <= '0;
      ent_q   <= '{default: '0};
    end else if (en_i && clr_i) begin
      count_q <= '0;
      ent_q   <= '{default: '0};
    end else if (en_i) begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
endmodule

// File: rtl/pond_port_arb.sv
// pond_port_arb: single SRAM port arbiter, reads win, writes deferred in order; POND_ARB_FWD_EN enables read forwarding from the write buffer
module pond_port_arb
  import pond_arb_pkg::*;
#(
  parameter int ADDR_W     = POND_ADDR_W,
  parameter int DATA_W     = POND_DATA_W,
  parameter int WBUF_DEPTH = POND_WBUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(WBUF_DEPTH + 1);
`ifdef POND_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  wbuf_entry_t           head, push_ent;
  logic [CW-1:0]         count;
  logic [WBUF_DEPTH-1:0] match;
  logic [DATA_W-1:0]     hit_data;
  logic live, full, hazard, rd_acc, wr_acc, fwd_hit, rd_port, drain, direct, push;
  logic rd_valid_q, fwd_q;
  logic [DATA_W-1:0] fwd_data_q;
  pond_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk), .rst(rst), .en_i(clk_en), .clr_i(flush), .push_i(push), .pop_i(drain),
    .push_ent_i(push_ent), .match_addr_i(rd_addr), .head_o(head), .count_o(count),
    .match_o(match), .hit_data_o(hit_data)
  );
  // port arbitration: read > buffered drain > direct write; a full buffer forces a drain
  always_comb begin
    live     = clk_en & ~rst & ~flush;
    full     = count == CW'(WBUF_DEPTH);
    hazard   = ~FWD & |match;
    wr_ready = live & ~full;
    rd_ready = live & ~full & ~hazard;
    rd_acc   = rd_req & rd_ready;
    wr_acc   = wr_req & wr_ready;
    fwd_hit  = FWD & rd_acc & |match;
    rd_port  = rd_acc & ~fwd_hit;
    drain    = live & ~rd_port & head.valid;
    direct   = wr_acc & ~rd_port & ~head.valid;
    push     = wr_acc & (rd_port | head.valid);
    push_ent = '{valid: 1'b1, addr: wr_addr, data: wr_data};
    mem_en   = rd_port | drain | direct;
    mem_wen  = drain | direct;
    mem_addr = rd_port ? rd_addr : drain ? head.addr : wr_addr;
    mem_wdata = drain ? head.data : wr_data;
  end
  // read response: valid one cycle after acceptance; forwarded data is captured at acceptance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (clk_en) begin
      rd_valid_q <= rd_acc;
      fwd_q      <= fwd_hit;
      if (fwd_hit) fwd_data_q <= hit_data;
    end
  assign rd_valid = rd_valid_q;
  assign rd_data  = fwd_q ? fwd_data_q : mem_rdata;
endmodule

// File: tb/tb_pond_port_arb.sv
// tb_pond_port_arb: table-driven and hand-sequenced checks of pond_port_arb with a read-data scoreboard
module tb_pond_port_arb;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, flush = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [4:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic wr_ready, rd_ready, rd_valid, mem_en, mem_wen;
  logic [15:0] rd_data, mem_wdata, mem_rdata;
  logic [4:0] mem_addr;
  logic [15:0] sram [32];
  logic [15:0] ref_mem [32];
  logic [15:0] sb [$];
  int checks = 0, failures = 0;

  typedef struct {
    logic wq; logic [4:0] wa; logic [15:0] wd;
    logic rq; logic [4:0] ra; logic fl; logic ce;
    logic ewr; logic erd; logic een; logic ewen; logic [4:0] ea; logic [15:0] ewd;
  } vec_t;

  pond_port_arb dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) begin
    sram[i] = 16'h1000 + 16'(i);
    ref_mem[i] = 16'h1000 + 16'(i);
  end

  always @(posedge clk)
    if (mem_en) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected no response at %0t", rd_data, $time);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, e, $time);
        end
      end
    end

  function automatic vec_t mk(input logic wq, input logic [4:0] wa, input logic [15:0] wd,
                              input logic rq, input logic [4:0] ra, input logic fl, input logic ce,
                              input logic ewr, input logic erd, input logic een, input logic ewen,
                              input logic [4:0] ea, input logic [15:0] ewd);
    vec_t v;
    v.wq = wq; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra; v.fl = fl; v.ce = ce;
    v.ewr = ewr; v.erd = erd; v.een = een; v.ewen = ewen; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic run_row(input vec_t v);
    @(posedge clk);
    #1;
    wr_req = v.wq; wr_addr = v.wa; wr_data = v.wd;
    rd_req = v.rq; rd_addr = v.ra; flush = v.fl; clk_en = v.ce;
    @(negedge clk);
    chk("wr_ready", 32'(wr_ready), 32'(v.ewr));
    chk("rd_ready", 32'(rd_ready), 32'(v.erd));
    chk("mem_en", 32'(mem_en), 32'(v.een));
    if (v.een) begin
      chk("mem_wen", 32'(mem_wen), 32'(v.ewen));
      chk("mem_addr", 32'(mem_addr), 32'(v.ea));
    end
    if (v.een && v.ewen) chk("mem_wdata", 32'(mem_wdata), 32'(v.ewd));
    if (v.rq && v.erd) sb.push_back(ref_mem[v.ra]);
    if (v.wq && v.ewr) ref_mem[v.wa] = v.wd;
  endtask

  function automatic vec_t idle(input logic ewr, input logic erd);
    return mk(0, 0, 0, 0, 0, 0, 1, ewr, erd, 0, 0, 0, 0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [16];
    logic [15:0] old_a, old_b;
    tbl[0]  = mk(1, 0, 16'hA0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 16'hA0);
    tbl[1]  = mk(1, 1, 16'hA1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 16'hA1);
    tbl[2]  = mk(1, 2, 16'hA2, 0, 0, 0, 1, 1, 1, 1, 1, 2, 16'hA2);
    tbl[3]  = mk(1, 3, 16'hA3, 0, 0, 0, 1, 1, 1, 1, 1, 3, 16'hA3);
    tbl[4]  = mk(1, 5, 16'h1234, 1, 9, 0, 1, 1, 1, 1, 0, 9, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 5, 16'h1234);
    tbl[6]  = mk(1, 11, 16'hB0, 1, 10, 0, 1, 1, 1, 1, 0, 10, 0);
    tbl[7]  = mk(1, 13, 16'hB1, 1, 12, 0, 1, 1, 1, 1, 0, 12, 0);
    tbl[8]  = mk(1, 15, 16'hB2, 1, 14, 0, 1, 0, 0, 1, 1, 11, 16'hB0);
    tbl[9]  = mk(1, 15, 16'hB2, 1, 14, 0, 1, 1, 1, 1, 0, 14, 0);
    tbl[10] = mk(0, 0, 0, 1, 16, 0, 1, 0, 0, 1, 1, 13, 16'hB1);
    tbl[11] = mk(0, 0, 0, 1, 16, 0, 1, 1, 1, 1, 0, 16, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 15, 16'hB2);
    tbl[13] = idle(1, 1);
    tbl[14] = mk(1, 1, 16'hEE, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = idle(1, 1);

    #2;
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) run_row(tbl[i]);

    // same-cycle read and write to one address: read sees the old word
    run_row(mk(1, 22, 16'h5555, 1, 22, 0, 1, 1, 1, 1, 0, 22, 0));
    run_row(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 22, 16'h5555));

    // read hitting a buffered write
    run_row(mk(1, 7, 16'hBEEF, 1, 20, 0, 1, 1, 1, 1, 0, 20, 0));
`ifdef POND_ARB_FWD_EN
    run_row(mk(0, 0, 0, 1, 7, 0, 1, 1, 1, 1, 1, 7, 16'hBEEF));
`else
    run_row(mk(0, 0, 0, 1, 7, 0, 1, 1, 0, 1, 1, 7, 16'hBEEF));
    run_row(mk(0, 0, 0, 1, 7, 0, 1, 1, 1, 1, 0, 7, 0));
`endif
    run_row(idle(1, 1));

    // flush with two pending writes
    old_a = ref_mem[25];
    old_b = ref_mem[27];
    run_row(mk(1, 25, 16'hF1, 1, 24, 0, 1, 1, 1, 1, 0, 24, 0));
    run_row(mk(1, 27, 16'hF2, 1, 26, 0, 1, 1, 1, 1, 0, 26, 0));
    run_row(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    ref_mem[25] = old_a;
    ref_mem[27] = old_b;
    run_row(idle(1, 1));
    run_row(mk(0, 0, 0, 1, 25, 0, 1, 1, 1, 1, 0, 25, 0));
    run_row(mk(0, 0, 0, 1, 27, 0, 1, 1, 1, 1, 0, 27, 0));
    run_row(idle(1, 1));

    // asynchronous reset while a buffered write is draining
    old_a = ref_mem[29];
    run_row(mk(1, 29, 16'hD1, 1, 28, 0, 1, 1, 1, 1, 0, 28, 0));
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk("drain_mem_wen", 32'(mem_en & mem_wen), 1);
    chk("drain_mem_addr", 32'(mem_addr), 29);
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_en", 32'(mem_en), 0);
    chk("arst_wr_ready", 32'(wr_ready), 0);
    chk("arst_rd_ready", 32'(rd_ready), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    ref_mem[29] = old_a;
    @(posedge clk);
    #1 rst = 1'b0;
    run_row(idle(1, 1));
    run_row(mk(0, 0, 0, 1, 29, 0, 1, 1, 1, 1, 0, 29, 0));
    run_row(idle(1, 1));
    run_row(idle(1, 1));

    for (int i = 0; i < 32; i++) chk($sformatf("sram_%0d", i), 32'(sram[i]), 32'(ref_mem[i]));
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
